bitblade_slice_scheduler: RTL
=============================

Name: bitblade_slice_scheduler

Overview:
- Sequences one bit-flexible multiply-accumulate pass over 2-bit operand slices.
- On start it walks every (activation slice, weight slice) pair and issues slice indices to the PE array.
- It drives the PE shift stage's 3-bit shift code, time-aligned with the returning PE sum, and accumulates the 20-bit shifted sums into one signed result.
- It sits between the tile sequencer (start/result handshake) and the PE array plus PE shift datapath.

Parameters:
- PE_LAT, 2, cycles from issue_valid to the matching shifted_sum_in (>=1).
- ACC_W, 24, accumulator/result width (>=20).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  request a pass; accepted when start & start_ready.
- act_slices  in  2  activation slice count minus 1 (0..3 = 1..4 slices); sampled at accept.
- wgt_slices  in  2  weight slice count minus 1; sampled at accept.
- start_ready  out  1  high only in IDLE.
- issue_valid  out  1  slice pair presented to PE array this cycle.
- act_idx  out  2  activation slice index.
- wgt_idx  out  2  weight slice index.
- shift_signal  out  3  to PE shift stage; equals act_idx+wgt_idx of the issue made PE_LAT cycles earlier.
- shifted_sum_in  in  20  signed shifted PE sum returned from the PE shift stage.
- result  out  ACC_W  signed accumulated result.
- result_valid  out  1  result held valid.
- result_ready  in  1  consumer accepts result.
- busy  out  1  high in RUN or DRAIN.

Behaviour:
- Clock clk; reset synchronous, active-high, name reset.
- Reset: state IDLE; all outputs 0 except start_ready=1; accumulator, counters and delay line cleared.
- Reset mid-pass aborts immediately; in-flight returns are discarded.
- FSM states and transitions:
  - IDLE -> RUN on accept. Accept latches A=act_slices+1 and W=wgt_slices+1, clears accumulator, sets indices to (0,0).
  - RUN: issue_valid=1 every cycle. Order: outer loop act_idx 0..A-1, inner loop wgt_idx 0..W-1. N=A*W issue cycles. After issuing (A-1,W-1) -> DRAIN.
  - DRAIN: issue_valid=0; wait until all N returns are accumulated -> DONE.
  - DONE: result_valid=1, result stable; on result_ready -> IDLE (start_ready=1 next cycle).
- act_idx/wgt_idx are 0 when issue_valid=0.
- Return alignment:
  - PE_LAT-deep delay line carries {valid, act_idx+wgt_idx}; its output drives shift_signal (0 when not valid).
  - When the delayed valid is high, shifted_sum_in is sign-extended to ACC_W and added to the accumulator at that clock edge.
  - shifted_sum_in is ignored otherwise.
- Latency: accept at cycle T; issues T+1..T+N; last accumulate at edge ending cycle T+N+PE_LAT; result_valid high from cycle T+N+PE_LAT+1.
- Start while busy or in DONE is ignored; no queueing.
- result_ready outside DONE is ignored.
- Arithmetic: two's-complement, wraps modulo 2^ACC_W unless saturation is enabled.

Optional Feature:
- Macro: BITBLADE_ACC_SAT_EN.
- Defined: each add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A sticky sat_flag output (1 bit, cleared on accept, valid with result) records any clamp.
- Undefined: plain wrapping add; no sat_flag port.

Decomposition:
- Package bitblade_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - SLICE_IDX_W=2, SHIFT_CODE_W=3, PE_SHIFT_OUT_W=20;
  - a function sign-extending 20 bits to ACC_W.
- One sub-module, bitblade_valid_delay: parameterised-depth valid/shift-code delay line.

Test Plan:
- Reset, then A=1,W=1, returned shifted_sum=20'hFFFFF -> one issue (0,0), shift_signal=0 at T+1+PE_LAT, result=24'hFFFFFF, result_valid at T+4 (PE_LAT=2).
- A=2,W=2, bench PE model returns 1<<(2*shift_signal) -> issue order (0,0),(0,1),(1,0),(1,1), shift codes 0,1,1,2, result=25.
- A=4,W=4, all returns zero, result_ready held low 5 cycles -> 16 issues, result=0 held stable, start pulses in DONE ignored, start_ready=1 the cycle after result_ready.
- Reset asserted on the 3rd RUN cycle -> next cycle IDLE, busy=0, result_valid=0; a subsequent A=1,W=1 pass with return 20'h00005 gives result=5 uncorrupted.
- ACC_W=20, A=4,W=4, PE model returns 127<<(2*shift_signal) -> without macro result=20'hE0047; with BITBLADE_ACC_SAT_EN result=20'h7FFFF, sat_flag=1.
- Back-to-back: start held high -> second pass accepted the first cycle start_ready=1 after handshake; accumulator starts from 0.

Source files
------------

// File: rtl/bitblade_pkg.sv
// bitblade_pkg: shared types, widths and helpers for the BitBlade slice scheduler.
package bitblade_pkg;

  localparam int unsigned SLICE_IDX_W    = 2;
  localparam int unsigned SHIFT_CODE_W   = 3;
  localparam int unsigned PE_SHIFT_OUT_W = 20;
  localparam int unsigned SEXT_MAX_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bb_state_e;

  // Sign-extends a PE shift-stage sum to the widest supported accumulator;
  // callers truncate the result to their own ACC_W with a width cast.
  function automatic logic [SEXT_MAX_W-1:0] sext_pe_sum(input logic [PE_SHIFT_OUT_W-1:0] v);
    return {{(SEXT_MAX_W-PE_SHIFT_OUT_W){v[PE_SHIFT_OUT_W-1]}}, v};
  endfunction

endpackage

// File: rtl/bitblade_valid_delay.sv
// bitblade_valid_delay: DEPTH-stage delay line carrying {valid, shift code}.
// The code is forced to zero in any stage whose valid is low.
module bitblade_valid_delay #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CODE_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [CODE_W-1:0] code_i,
  output logic              valid_o,
  output logic [CODE_W-1:0] code_o
);

  logic [DEPTH-1:0]  vld_q;
  logic [CODE_W-1:0] code_q [DEPTH];

  // Shift the valid/code pair one stage per clock; reset empties the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) code_q[i] <= '0;
    end else begin
      vld_q[0]  <= valid_i;
      code_q[0] <= valid_i ? code_i : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        code_q[i] <= code_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign code_o  = code_q[DEPTH-1];

endmodule

// File: rtl/bitblade_slice_scheduler.sv
// bitblade_slice_scheduler: walks all (activation, weight) slice pairs of one
// MAC pass, issues them to the PE array, time-aligns the shift code with the
// returning PE sum and accumulates the shifted sums into a signed result.
// Optional macro BITBLADE_ACC_SAT_EN: saturating accumulation plus sat_flag.
module bitblade_slice_scheduler
  import bitblade_pkg::*;
#(
  parameter int unsigned PE_LAT = 2,
  parameter int unsigned ACC_W  = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [SLICE_IDX_W-1:0]    act_slices,
  input  logic [SLICE_IDX_W-1:0]    wgt_slices,
  output logic                      start_ready,
  output logic                      issue_valid,
  output logic [SLICE_IDX_W-1:0]    act_idx,
  output logic [SLICE_IDX_W-1:0]    wgt_idx,
  output logic [SHIFT_CODE_W-1:0]   shift_signal,
  input  logic [PE_SHIFT_OUT_W-1:0] shifted_sum_in,
  output logic [ACC_W-1:0]          result,
  output logic                      result_valid,
`ifdef BITBLADE_ACC_SAT_EN
  output logic                      sat_flag,
`endif
  input  logic                      result_ready,
  output logic                      busy
);

  localparam int unsigned CNT_W = 2*SLICE_IDX_W + 1;

  bb_state_e              state_q, state_d;
  logic [SLICE_IDX_W-1:0] a_max_q, a_max_d;
  logic [SLICE_IDX_W-1:0] w_max_q, w_max_d;
  logic [SLICE_IDX_W-1:0] act_q, act_d;
  logic [SLICE_IDX_W-1:0] wgt_q, wgt_d;
  logic [CNT_W-1:0]       rcnt_q, rcnt_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
`ifdef BITBLADE_ACC_SAT_EN
  logic                   sat_q, sat_d;
  logic                   ovf;
`endif

  logic                    accept;
  logic                    last_issue;
  logic [CNT_W-1:0]        n_total;
  logic [SHIFT_CODE_W-1:0] issue_code;
  logic                    dly_valid;
  logic [SHIFT_CODE_W-1:0] dly_code;
  logic [ACC_W-1:0]        sum_ext;
  logic [ACC_W-1:0]        sum_wrap;

  assign accept     = start && (state_q == IDLE);
  assign last_issue = (act_q == a_max_q) && (wgt_q == w_max_q);
  assign n_total    = ({{(CNT_W-SLICE_IDX_W){1'b0}}, a_max_q} + CNT_W'(1)) *
                      ({{(CNT_W-SLICE_IDX_W){1'b0}}, w_max_q} + CNT_W'(1));
  assign issue_code = {1'b0, act_q} + {1'b0, wgt_q};

  // State, slice-count and index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_max_q <= '0;
      w_max_q <= '0;
      act_q   <= '0;
      wgt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_max_q <= a_max_d;
      w_max_q <= w_max_d;
      act_q   <= act_d;
      wgt_q   <= wgt_d;
    end
  end

  // Next-state, index walk (act outer, wgt inner) and handshake outputs.
  always_comb begin
    state_d      = state_q;
    a_max_d      = a_max_q;
    w_max_d      = w_max_q;
    act_d        = act_q;
    wgt_d        = wgt_q;
    start_ready  = 1'b0;
    issue_valid  = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start) begin
          state_d = RUN;
          a_max_d = act_slices;
          w_max_d = wgt_slices;
          act_d   = '0;
          wgt_d   = '0;
        end
      end
      RUN: begin
        issue_valid = 1'b1;
        busy        = 1'b1;
        if (last_issue) begin
          state_d = DRAIN;
          act_d   = '0;
          wgt_d   = '0;
        end else if (wgt_q == w_max_q) begin
          wgt_d = '0;
          act_d = act_q + SLICE_IDX_W'(1);
        end else begin
          wgt_d = wgt_q + SLICE_IDX_W'(1);
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave once the final outstanding return is being accumulated.
        if (dly_valid && ((rcnt_q + CNT_W'(1)) == n_total)) state_d = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign act_idx = issue_valid ? act_q : '0;
  assign wgt_idx = issue_valid ? wgt_q : '0;

  bitblade_valid_delay #(
    .DEPTH  (PE_LAT),
    .CODE_W (SHIFT_CODE_W)
  ) u_valid_delay (
    .clk     (clk),
    .reset   (reset),
    .valid_i (issue_valid),
    .code_i  (issue_code),
    .valid_o (dly_valid),
    .code_o  (dly_code)
  );

  assign shift_signal = dly_code;

  assign sum_ext  = ACC_W'(sext_pe_sum(shifted_sum_in));
  assign sum_wrap = acc_q + sum_ext;
`ifdef BITBLADE_ACC_SAT_EN
  // Signed overflow: operands share a sign that the wrapped sum lost.
  assign ovf = (acc_q[ACC_W-1] == sum_ext[ACC_W-1]) && (sum_wrap[ACC_W-1] != acc_q[ACC_W-1]);
`endif

  // Accumulate aligned returns; accept starts a fresh pass from zero.
  always_comb begin
    acc_d  = acc_q;
    rcnt_d = rcnt_q;
`ifdef BITBLADE_ACC_SAT_EN
    sat_d  = sat_q;
`endif
    if (accept) begin
      acc_d  = '0;
      rcnt_d = '0;
`ifdef BITBLADE_ACC_SAT_EN
      sat_d  = 1'b0;
`endif
    end else if (dly_valid) begin
      rcnt_d = rcnt_q + CNT_W'(1);
      acc_d  = sum_wrap;
`ifdef BITBLADE_ACC_SAT_EN
      if (ovf) begin
        acc_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        sat_d = 1'b1;
      end
`endif
    end
  end

  // Accumulator, return counter and sticky clamp flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      rcnt_q <= '0;
`ifdef BITBLADE_ACC_SAT_EN
      sat_q  <= 1'b0;
`endif
    end else begin
      acc_q  <= acc_d;
      rcnt_q <= rcnt_d;
`ifdef BITBLADE_ACC_SAT_EN
      sat_q  <= sat_d;
`endif
    end
  end

  assign result = acc_q;
`ifdef BITBLADE_ACC_SAT_EN
  assign sat_flag = sat_q;
`endif

endmodule
